// File: rtl/led_ctrl_pkg.sv
// Shared state encoding and widths for the LED step sequencer.
// The state values are visible on the state output port, so they must not be reordered.
package led_ctrl_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_PAUSED = 2'd2;

    localparam int STEP_CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_RUN    = ST_RUN,
        S_PAUSED = ST_PAUSED
    } led_state_t;

endpackage

// File: rtl/button_debounce.sv
// Synchronises and debounces a raw push button.
// Produces a clean level (btn_db) and a one-cycle press pulse on its rising edge.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_db,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic             btn_db_d;
    logic [CNT_W-1:0] stable_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0    <= 1'b0;
            sync_p1    <= 1'b0;
            btn_db     <= 1'b0;
            btn_db_d   <= 1'b0;
            press      <= 1'b0;
            stable_cnt <= '0;
        end else begin
            sync_p0  <= btn_raw;
            sync_p1  <= sync_p0;
            btn_db_d <= btn_db;
            // Registered edge detect: keeps the press-to-step path one flop deep.
            press    <= btn_db & ~btn_db_d;

            // Only a run of samples that disagree with btn_db counts; any agreeing sample restarts it.
            if (sync_p1 != btn_db) begin
                if (stable_cnt == CNT_LAST) begin
                    btn_db     <= sync_p1;
                    stable_cnt <= '0;
                end else begin
                    stable_cnt <= stable_cnt + CNT_W'(1);
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/led_step_ctrl.sv
// Step sequencer for the LED colour cycler: idle/run/paused FSM with auto-step timer,
// single-step on press and long-hold resume. Emits isolated one-cycle step pulses only.
module led_step_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int BASE_TICKS      = 8,
    parameter int LONG_CYCLES     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  btn_raw,
    input  logic                  auto_en,
    input  logic [1:0]            rate_sel,
    output logic                  step,
    output logic [1:0]            state,
    output logic                  btn_db,
    output logic [STEP_CNT_W-1:0] step_count
);

    localparam int TIMER_W = $clog2(BASE_TICKS << 3) + 1;
    localparam int HOLD_W  = $clog2(LONG_CYCLES) + 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    function automatic logic [TIMER_W-1:0] reload_val(input logic [1:0] rs);
        reload_val = TIMER_W'(BASE_TICKS << rs);
    endfunction

    logic               press;
    led_state_t         cur_st;
    logic [TIMER_W-1:0] timer;
    logic [HOLD_W-1:0]  hold_cnt;
    logic               hold_arm;
    logic               expire;
    logic               fire;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(btn_raw),
        .btn_db (btn_db),
        .press  (press)
    );

    assign state  = cur_st;
    assign expire = (timer <= TIMER_W'(1));

    // A press in RUN pauses instead of stepping, unless auto_en is dropping this cycle.
    always_comb begin
        fire = 1'b0;
        case (cur_st)
            S_IDLE:   fire = press;
            S_RUN:    fire = press ? !auto_en : (auto_en && expire);
            S_PAUSED: fire = press;
            default:  fire = 1'b0;
        endcase
        if (step) begin
            fire = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_st     <= S_IDLE;
            step       <= 1'b0;
            timer      <= '0;
            hold_cnt   <= '0;
            hold_arm   <= 1'b0;
            step_count <= '0;
        end else begin
            step <= fire;
            if (fire) begin
                step_count <= step_count + STEP_CNT_W'(1);
            end

            if (!auto_en) begin
                cur_st   <= S_IDLE;
                hold_cnt <= '0;
                hold_arm <= 1'b0;
            end else begin
                case (cur_st)
                    S_IDLE: begin
                        cur_st <= S_RUN;
                        timer  <= reload_val(rate_sel);
                    end
                    S_RUN: begin
                        if (press) begin
                            cur_st   <= S_PAUSED;
                            hold_cnt <= '0;
                            hold_arm <= 1'b0;
                        end else if (expire) begin
                            timer <= reload_val(rate_sel);
                        end else begin
                            timer <= timer - TIMER_W'(1);
                        end
                    end
                    S_PAUSED: begin
                        // Only the hold that follows a single-step press may resume RUN.
                        if (press) begin
                            hold_arm <= 1'b1;
                            hold_cnt <= '0;
                        end else if (!btn_db) begin
                            hold_arm <= 1'b0;
                            hold_cnt <= '0;
                        end else if (hold_arm) begin
                            if (hold_cnt == HOLD_LAST) begin
                                cur_st   <= S_RUN;
                                timer    <= reload_val(rate_sel);
                                hold_arm <= 1'b0;
                                hold_cnt <= '0;
                            end else begin
                                hold_cnt <= hold_cnt + HOLD_W'(1);
                            end
                        end
                    end
                    default: cur_st <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_step_ctrl.sv
// Directed bench for led_step_ctrl with an edge-indexed scoreboard of expected steps
// and a small model of the downstream colour cycler.
module tb_led_step_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_raw;
    logic       auto_en;
    logic [1:0] rate_sel;
    logic       step;
    logic [1:0] state;
    logic       btn_db;
    logic [7:0] step_count;

    led_step_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .BASE_TICKS     (8),
        .LONG_CYCLES    (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .auto_en   (auto_en),
        .rate_sel  (rate_sel),
        .step      (step),
        .state     (state),
        .btn_db    (btn_db),
        .step_count(step_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Colour cycler: 0/7 -> 1, 6 -> 1, otherwise +1 on each step.
    logic [2:0] colour;
    always @(posedge clk) begin
        if (rst) colour <= 3'd0;
        else if (step === 1'b1) colour <= (colour == 3'd0 || colour == 3'd6 || colour == 3'd7) ? 3'd1 : colour + 3'd1;
    end

    typedef struct {
        int edge_n;
        int cnt;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic expect_step(input int edge_n, input int cnt);
        exp_q.push_back('{edge_n: edge_n, cnt: cnt});
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_edge(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Monitor: every step must match the head of the scoreboard in edge and count.
    logic step_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (step === 1'b1) begin
            chk("step_spacing", step_prev, 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_step_edge", cyc, 0);
            end else begin
                e = exp_q.pop_front();
                chk("step_edge", cyc, e.edge_n);
                chk("step_count_at_step", step_count, e.cnt);
            end
        end else if (exp_q.size() != 0 && exp_q[0].edge_n <= cyc) begin
            e = exp_q.pop_front();
            chk("missed_step_edge", cyc, e.edge_n + 1000000);
        end
        step_prev = step;
    end

    initial begin
        int n;
        int e0;
        int p;
        int r;
        rst      = 1'b1;
        btn_raw  = 1'b0;
        auto_en  = 1'b0;
        rate_sel = 2'd0;

        // Reset
        cycles(2);
        chk("rst_step", step, 0);
        chk("rst_state", state, 0);
        chk("rst_step_count", step_count, 0);
        chk("rst_btn_db", btn_db, 0);
        rst = 1'b0;
        cycles(3);

        // IDLE: one held press gives exactly one step, DEBOUNCE+3 edges later
        n = cyc + 1;
        btn_raw = 1'b1;
        expect_step(n + 7, 1);
        cycles(20);
        btn_raw = 1'b0;
        chk("idle_state", state, 0);
        chk("held_btn_db", btn_db, 1);
        cycles(10);
        chk("released_btn_db", btn_db, 0);
        chk("idle_step_count", step_count, 1);
        chk("idle_colour", colour, 1);

        // Short glitch is filtered
        btn_raw = 1'b1;
        cycles(3);
        btn_raw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cycles(1);
            chk("glitch_btn_db", btn_db, 0);
        end
        chk("glitch_step_count", step_count, 1);
        chk("glitch_colour", colour, 1);

        // RUN: period 8, then 32 after the next reload
        e0 = cyc + 1;
        auto_en  = 1'b1;
        rate_sel = 2'd0;
        expect_step(e0 + 8, 2);
        expect_step(e0 + 16, 3);
        expect_step(e0 + 48, 4);
        expect_step(e0 + 80, 5);
        expect_step(e0 + 112, 6);
        expect_step(e0 + 144, 7);
        cycles(1);
        chk("run_state", state, 1);
        wait_edge(e0 + 10);
        rate_sel = 2'd2;
        wait_edge(e0 + 145);
        chk("run_colour_wrap", colour, 1);
        chk("run_step_count", step_count, 7);
        chk("run_state_still", state, 1);

        // Press landing on the same edge as timer expiry pauses without stepping
        wait_edge(e0 + 168);
        btn_raw = 1'b1;
        wait_edge(e0 + 177);
        chk("pause_state", state, 2);
        chk("pause_step_count", step_count, 7);
        wait_edge(e0 + 180);
        btn_raw = 1'b0;
        cycles(12);

        // Short press in PAUSED: single step, stay paused
        n = cyc + 1;
        btn_raw = 1'b1;
        expect_step(n + 7, 8);
        cycles(8);
        btn_raw = 1'b0;
        cycles(15);
        chk("single_step_state", state, 2);
        chk("single_step_count", step_count, 8);

        // Long press: single step, then resume RUN after 16 held cycles with no extra step
        rate_sel = 2'd0;
        n = cyc + 1;
        btn_raw = 1'b1;
        p = n + 7;
        r = p + 16;
        expect_step(p, 9);
        expect_step(r + 8, 10);
        expect_step(r + 16, 11);
        wait_edge(r - 1);
        chk("hold_before_resume", state, 2);
        cycles(1);
        chk("hold_resumed", state, 1);
        cycles(2);
        btn_raw = 1'b0;

        // auto_en low returns to IDLE next cycle and stops auto steps
        wait_edge(r + 17);
        auto_en = 1'b0;
        cycles(1);
        chk("auto_off_state", state, 0);
        cycles(40);
        chk("auto_off_step_count", step_count, 11);
        chk("auto_off_colour", colour, 5);
        chk("auto_off_state_still", state, 0);

        // Reset mid-operation
        n = cyc + 1;
        auto_en = 1'b1;
        btn_raw = 1'b1;
        wait_edge(n + 9);
        chk("pre_rst_state", state, 2);
        chk("pre_rst_btn_db", btn_db, 1);
        rst = 1'b1;
        cycles(1);
        chk("mid_rst_step", step, 0);
        chk("mid_rst_state", state, 0);
        chk("mid_rst_step_count", step_count, 0);
        chk("mid_rst_btn_db", btn_db, 0);
        rst     = 1'b0;
        auto_en = 1'b0;
        btn_raw = 1'b0;
        cycles(20);
        chk("post_rst_state", state, 0);
        chk("post_rst_step_count", step_count, 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
